uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx_byte transmitter among NUM_REQ byte sources (e.g. RX echo, command acknowledge, status report from the LED controller).
- Accepts level requests with a byte each and grants them round-robin.
- Issues a single-cycle tx_start to the transmitter, then waits for tx_done.
- Enforces a guard gap between bytes and recovers from a transmitter that never completes.

Parameters:
- NUM_REQ, 3, number of requesters (1..8).
- GUARD_CYCLES, 16, idle sys_clk cycles inserted after each byte before the next grant (0 = none).
- TIMEOUT_CYCLES, 2000000, max cycles to wait for tx_done after tx_start before abort.
- GW, $clog2(NUM_REQ) (min 1), grant index width (derived, not overridden).

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  level request; requester i holds req[i] high until it sees req_ack[i].
- req_data  in  NUM_REQ*8  byte of requester i on bits [8i+7:8i]; valid while req[i] is high.
- req_ack  out  NUM_REQ  one-cycle pulse on the granted requester's bit when its byte is launched.
- tx_start  out  1  one-cycle start pulse to uart_tx_byte.
- tx_data  out  8  byte to transmitter; stable from the tx_start cycle until leaving WAIT_DONE.
- tx_done  in  1  one-cycle completion pulse from uart_tx_byte.
- grant_id  out  GW  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  one-cycle pulse when a byte is aborted on timeout.

Behaviour:
- Reset values (async, immediate): state=IDLE; req_ack=0, tx_start=0, tx_data=8'h00, grant_id=NUM_REQ-1, busy=0, timeout_err=0; counters=0; RR pointer=NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, LAUNCH, WAIT_DONE, GUARD.
- IDLE: on a clock edge where |req=1, pick the first set req bit searching from (ptr+1) mod NUM_REQ upward with wrap. On that edge: register grant_id and ptr, latch tx_data, go to LAUNCH.
- LAUNCH: lasts exactly one cycle, with tx_start=1 and req_ack[grant_id]=1 in that same cycle. Next state is WAIT_DONE; clear the timeout counter.
- Latency: req sampled high at edge N gives tx_start/req_ack high during cycle N+1.
- WAIT_DONE: on tx_done=1, go to GUARD. Otherwise increment the timeout counter; when it reaches TIMEOUT_CYCLES-1, pulse timeout_err for one cycle and go to GUARD.
  - tx_done and the timeout edge in the same cycle: tx_done wins, no timeout_err.
- GUARD: count GUARD_CYCLES cycles, then go to IDLE. If GUARD_CYCLES=0, WAIT_DONE goes straight to IDLE.
- Back-to-back throughput: one byte per (1 + 1 + tx time + GUARD_CYCLES) cycles minimum.
- tx_done outside WAIT_DONE (including the LAUNCH cycle) is ignored.
- Grant is committed at the IDLE sampling edge.
  - A requester dropping req afterwards does not cancel its byte; ack is still pulsed.
  - A requester changing req_data after the grant edge does not affect tx_data.
- A requester holding req through its ack is re-granted only after all other pending requesters have had a turn (fairness).
- Requests arriving while busy are held pending by the requester and are not lost.
- Timeout counter width is $clog2(TIMEOUT_CYCLES)+1. The guard counter width covers GUARD_CYCLES. No wrap is possible.
- Reset mid-operation: all outputs return to reset values asynchronously. A partially sent byte in the transmitter is not tracked.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding constants (IDLE=2'd0, LAUNCH=2'd1, WAIT_DONE=2'd2, GUARD=2'd3);
  - the default GUARD_CYCLES and TIMEOUT_CYCLES values, so top levels and benches agree.
- One sub-module, rr_arb_pick: purely combinational rotate–priority-encode–unrotate.
  - Inputs: req and ptr.
  - Outputs: winner index and valid.
- FSM, counters and the data mux stay in uart_tx_arbiter.

Test Plan:
- Single request: NUM_REQ=3, req=3'b010, req_data[15:8]=8'hA5 → tx_start and req_ack=3'b010 in the next cycle; tx_data=8'hA5; grant_id=1; busy high until GUARD ends.
- Round-robin: req=3'b111 held, bytes 8'h11/8'h22/8'h33, tx_done returned after 20 cycles each → launch order 0,1,2,0, with tx_start spacing 2+20+GUARD_CYCLES cycles.
- Late data change: change req_data[7:0] from 8'h55 to 8'hAA one cycle after the grant edge → tx_data stays 8'h55 until tx_done.
- Timeout: TIMEOUT_CYCLES=50, tx_done never asserted → timeout_err pulses exactly 50 cycles after tx_start; FSM goes GUARD then IDLE; a pending req[2] is then granted.
- Coincidence and stray done:
  - tx_done on the same edge the timeout would fire → no timeout_err.
  - Stray tx_done in IDLE → no state change.
- Async reset during WAIT_DONE → tx_data=0, busy=0, grant_id=2 immediately. After release, req=3'b101 grants requester 0 first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default timing
// parameters and a width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GUARD     = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_GUARD_CYCLES   = 16;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 2000000;

    // $clog2 clamped to at least one bit so single-entry fields stay legal
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: rotate requests to start just after ptr,
// take the lowest set bit, then map the offset back to a requester index.
module rr_arb_pick
    import uart_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 3,
    localparam int unsigned GW      = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      winner,
    output logic               valid
);

    localparam int unsigned   SW   = GW + 1;
    localparam logic [GW-1:0] LAST = GW'(NUM_REQ - 1);

    logic [GW-1:0]      start;
    logic [NUM_REQ-1:0] rot;
    logic [GW-1:0]      off;
    logic [SW-1:0]      sum;
    logic               found;

    always_comb begin
        start = (ptr >= LAST) ? '0 : ptr + GW'(1);
        rot   = NUM_REQ'({req, req} >> start);
        off   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rot[i] && !found) begin
                off   = GW'(i);
                found = 1'b1;
            end
        end
        // Un-rotate modulo NUM_REQ
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= SW'(NUM_REQ)) begin
            sum = sum - SW'(NUM_REQ);
        end
        winner = sum[GW-1:0];
        valid  = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx_byte among several byte sources, with
// a one-cycle launch, completion wait with timeout abort, and an inter-byte guard gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned NUM_REQ        = 3,
    parameter  int unsigned GUARD_CYCLES   = DEFAULT_GUARD_CYCLES,
    parameter  int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int unsigned GW             = clog2_min1(NUM_REQ)
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic [GW-1:0]          grant_id,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int unsigned   TW           = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned   CW           = clog2_min1(GUARD_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST   = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    state_e             state_q, state_nx;
    logic [TW-1:0]      tcnt_q, tcnt_nx;
    logic [CW-1:0]      gcnt_q, gcnt_nx;
    logic [NUM_REQ-1:0] ack_nx;
    logic               start_nx, busy_nx, terr_nx;
    logic [7:0]         data_nx;
    logic [GW-1:0]      grant_nx;

    logic [GW-1:0]      pick_id;
    logic               pick_valid;
    logic [7:0]         pick_data;
    logic [NUM_REQ-1:0] pick_ack;
    logic               timeout_hit;
    logic               guard_last;

    // The last granted index doubles as the round-robin pointer
    rr_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req),
        .ptr    (grant_id),
        .winner (pick_id),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_data = 8'h00;
        pick_ack  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_id == GW'(i)) begin
                pick_data   = req_data[8*i +: 8];
                pick_ack[i] = 1'b1;
            end
        end
    end

    assign timeout_hit = (tcnt_q + TW'(1)) >= TIMEOUT_LAST;
    assign guard_last  = (gcnt_q == GUARD_LAST);

    // State and registered outputs
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tcnt_q      <= '0;
            gcnt_q      <= '0;
            req_ack     <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            grant_id    <= GW'(NUM_REQ - 1);
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_nx;
            tcnt_q      <= tcnt_nx;
            gcnt_q      <= gcnt_nx;
            req_ack     <= ack_nx;
            tx_start    <= start_nx;
            tx_data     <= data_nx;
            grant_id    <= grant_nx;
            busy        <= busy_nx;
            timeout_err <= terr_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:      if (pick_valid) state_nx = LAUNCH;
            LAUNCH:    state_nx = WAIT_DONE;
            WAIT_DONE: if (tx_done || timeout_hit) state_nx = (GUARD_CYCLES == 0) ? IDLE : GUARD;
            GUARD:     if (guard_last) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Next values for the registered outputs and counters
    always_comb begin
        ack_nx   = '0;
        start_nx = 1'b0;
        data_nx  = tx_data;
        grant_nx = grant_id;
        busy_nx  = (state_nx != IDLE);
        terr_nx  = 1'b0;
        tcnt_nx  = tcnt_q;
        gcnt_nx  = gcnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    ack_nx   = pick_ack;
                    start_nx = 1'b1;
                    data_nx  = pick_data;
                    grant_nx = pick_id;
                end
            end
            LAUNCH: tcnt_nx = '0;
            WAIT_DONE: begin
                gcnt_nx = '0;
                // A completion on the timeout edge counts as success
                if (!tx_done) begin
                    if (timeout_hit) terr_nx = 1'b1;
                    else             tcnt_nx = tcnt_q + TW'(1);
                end
            end
            GUARD: if (!guard_last) gcnt_nx = gcnt_q + CW'(1);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed stimulus queues expected launches
// and timeouts; a negedge monitor checks every tx_start and timeout_err against them.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int GUARD   = DEFAULT_GUARD_CYCLES;
    localparam int TIMEOUT = 50;
    localparam int GAP     = 2 + 20 + GUARD;

    typedef struct {
        logic [7:0] data;
        int         id;
        bit         from_prev;
        int         delay;
        int         ref_cyc;
    } launch_t;

    logic        sys_clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [23:0] req_data;
    logic [2:0]  req_ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    launch_t exp_q[$];
    int      to_q[$];
    launch_t mon_e;
    int      cyc = 0;
    int      last_start = 0;
    int      starts_seen = 0;
    int      terr_seen = 0;
    int      n_checks = 0;
    int      n_fail = 0;
    int      snap;

    uart_tx_arbiter #(
        .NUM_REQ        (3),
        .GUARD_CYCLES   (GUARD),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    task automatic expect_launch(input logic [7:0] d, input int id, input bit fp, input int dly);
        launch_t e;
        e.data = d; e.id = id; e.from_prev = fp; e.delay = dly; e.ref_cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_start();
        for (int n = 0; n < 200; n++) begin
            @(negedge sys_clk);
            if (tx_start) return;
        end
        fail_now("tx_start_wait");
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 400; n++) begin
            @(posedge sys_clk);
            #1;
            if (!busy) return;
        end
        fail_now("idle_wait");
    endtask

    // tx_done high during the k-th cycle after the current (launch) cycle
    task automatic done_after(input int k);
        repeat (k) @(posedge sys_clk);
        #1 tx_done = 1'b1;
        @(posedge sys_clk);
        #1 tx_done = 1'b0;
    endtask

    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (req_ack != 3'b000 && !tx_start) fail_now("ack_without_start");
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_launch");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(mon_e.data));
                    check("grant_id", 32'(grant_id), mon_e.id);
                    check("req_ack", 32'(req_ack), 32'(1) << mon_e.id);
                    check("launch_delay", cyc - (mon_e.from_prev ? last_start : mon_e.ref_cyc),
                          mon_e.delay);
                end
                last_start = cyc;
                starts_seen++;
            end
            if (timeout_err) begin
                terr_seen++;
                if (to_q.size() == 0) fail_now("unexpected_timeout_err");
                else check("timeout_delay", cyc - last_start, to_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        req = '0; req_data = '0; tx_done = 1'b0; rst_n = 1'b0;
        tick(2);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_grant_id", 32'(grant_id), 2);
        check("rst_busy", 32'(busy), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_req_ack", 32'(req_ack), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        rst_n = 1'b1;
        tick(2);

        // Round robin with all three requesters held
        req_data = {8'h33, 8'h22, 8'h11};
        expect_launch(8'h11, 0, 1'b0, 1);
        expect_launch(8'h22, 1, 1'b1, GAP);
        expect_launch(8'h33, 2, 1'b1, GAP);
        expect_launch(8'h11, 0, 1'b1, GAP);
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_start();
            if (i == 3) req = '0;
            done_after(20);
        end
        wait_idle();

        // Single request; busy spans exactly the guard gap
        req_data = 24'h00A500;
        expect_launch(8'hA5, 1, 1'b0, 1);
        req = 3'b010;
        wait_start();
        check("busy_launch", 32'(busy), 1);
        req = '0;
        done_after(20);
        tick(15);
        check("busy_guard_last", 32'(busy), 1);
        tick(1);
        check("busy_back_idle", 32'(busy), 0);
        check("grant_hold_idle", 32'(grant_id), 1);

        // Data change after the grant edge must not reach tx_data
        req_data = 24'h000055;
        expect_launch(8'h55, 0, 1'b0, 1);
        req = 3'b001;
        wait_start();
        tick(1);
        req_data[7:0] = 8'hAA;
        req = '0;
        tick(18);
        check("late_data_wait", 32'(tx_data), 32'h55);
        tick(1);
        tx_done = 1'b1;
        check("late_data_done", 32'(tx_data), 32'h55);
        tick(1);
        tx_done = 1'b0;
        wait_idle();

        // Timeout abort, then a pending requester 2 is served
        req_data = 24'hC3005A;
        expect_launch(8'h5A, 0, 1'b0, 1);
        req = 3'b001;
        wait_start();
        req = 3'b100;
        to_q.push_back(TIMEOUT);
        expect_launch(8'hC3, 2, 1'b1, 1 + TIMEOUT + GUARD);
        wait_start();
        req = '0;
        done_after(20);
        wait_idle();

        // tx_done on the cycle the timeout would fire
        req_data = 24'h000077;
        expect_launch(8'h77, 0, 1'b0, 1);
        req = 3'b001;
        wait_start();
        req = '0;
        snap = terr_seen;
        done_after(TIMEOUT - 1);
        wait_idle();
        check("coincident_no_timeout", terr_seen, snap);

        // Stray tx_done while idle
        snap = starts_seen;
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        tick(2);
        check("stray_busy", 32'(busy), 0);
        check("stray_no_launch", starts_seen, snap);
        check("stray_grant", 32'(grant_id), 0);

        // Stray tx_done in LAUNCH, then async reset during WAIT_DONE
        req_data = 24'h003C00;
        expect_launch(8'h3C, 1, 1'b0, 1);
        req = 3'b010;
        wait_start();
        tx_done = 1'b1;
        req = '0;
        tick(1);
        tx_done = 1'b0;
        tick(17);
        check("launch_done_ignored", 32'(busy), 1);
        check("wait_tx_data", 32'(tx_data), 32'h3C);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx_data", 32'(tx_data), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_grant_id", 32'(grant_id), 2);
        check("arst_tx_start", 32'(tx_start), 0);
        req_data = 24'h830081;
        req = 3'b101;
        tick(1);
        expect_launch(8'h81, 0, 1'b0, 1);
        expect_launch(8'h83, 2, 1'b1, GAP);
        rst_n = 1'b1;
        wait_start();
        req = 3'b100;
        done_after(20);
        wait_start();
        req = '0;
        done_after(20);
        wait_idle();

        tick(2);
        check("launch_queue_empty", exp_q.size(), 0);
        check("timeout_queue_empty", to_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
